// File: rtl/bidim_demux.sv
// bidim_demux: registered one-to-many distributor. One producer word per
// cycle is steered into one of DEPTH one-entry lane buffers (or all of them
// in broadcast mode), each drained by its own valid/ack consumer.
module bidim_demux #(
  parameter  int WIDTH      = 2,
  parameter  int DEPTH      = 4,
  localparam int TOTAL_BITS = WIDTH * DEPTH,
  localparam int SEL_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  m_clk,
  input  logic                  m_rst,
  input  logic [WIDTH-1:0]      m_in,
  input  logic [SEL_WIDTH-1:0]  m_ctrl,
  input  logic                  m_bcast,
  input  logic                  m_valid,
  output logic                  m_ready,
  output logic [TOTAL_BITS-1:0] m_out,
  output logic [DEPTH-1:0]      m_out_valid,
  input  logic [DEPTH-1:0]      m_out_ack,
  output logic                  m_err
);

  // Lane count widened by one bit so an all-ones select can be compared
  // against it even when DEPTH is a power of two.
  localparam logic [SEL_WIDTH:0] DEPTH_W = (SEL_WIDTH + 1)'(DEPTH);

  logic [TOTAL_BITS-1:0] out_reg;
  logic [DEPTH-1:0]      valid_reg;
  logic                  err_reg;

  logic                  in_range;
  logic [DEPTH-1:0]      lane_hit;
  logic [DEPTH-1:0]      lane_free;
  logic [DEPTH-1:0]      ack_eff;
  logic [DEPTH-1:0]      write_en;
  logic                  accept;

  assign in_range  = ({1'b0, m_ctrl} < DEPTH_W);
  // A lane can take a new word if it is empty or its consumer drains it now.
  assign lane_free = ~valid_reg | m_out_ack;
  // Acks on empty lanes carry no meaning and are dropped here.
  assign ack_eff   = valid_reg & m_out_ack;
  assign accept    = m_valid & m_ready;

  // Per-lane decode of the select and of the resulting write strobe.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
      assign lane_hit[gi] = in_range && (m_ctrl == SEL_WIDTH'(gi));
      assign write_en[gi] = accept && (m_bcast || lane_hit[gi]);
    end
  endgenerate

  // Ready: broadcast needs every lane free, a directed write needs its lane
  // free, and an out-of-range select is always taken (and dropped). While
  // reset is asserted the lanes are about to be emptied, so report ready.
  always_comb begin
    m_ready = 1'b1;
    if (m_rst) begin
      m_ready = 1'b1;
    end else if (m_bcast) begin
      m_ready = &lane_free;
    end else if (in_range) begin
      m_ready = |(lane_hit & lane_free);
    end else begin
      m_ready = 1'b1;
    end
  end

  // Lane buffers: a write wins over an ack (overwrite keeps the lane full);
  // an ack alone empties the lane but leaves its data untouched.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      out_reg   <= '0;
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (write_en[i]) begin
          out_reg[i*WIDTH +: WIDTH] <= m_in;
          valid_reg[i]              <= 1'b1;
        end else if (ack_eff[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky error on any accepted directed write that targets no lane.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      err_reg <= 1'b0;
    end else if (accept && !m_bcast && !in_range) begin
      err_reg <= 1'b1;
    end
  end

  assign m_out       = out_reg;
  assign m_out_valid = valid_reg;
  assign m_err       = err_reg;

endmodule

// File: tb/tb_bidim_demux.sv
// Directed bench for bidim_demux: a 4-lane instance for the main behaviour
// and a 3-lane instance for out-of-range selects.
module tb_bidim_demux;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 4-lane instance
  logic       rst, bcast, valid;
  logic [1:0] din, ctrl;
  logic [3:0] ack;
  logic       ready, err;
  logic [7:0] dout;
  logic [3:0] ovalid;

  // 3-lane instance
  logic       r3_rst, r3_bcast, r3_valid;
  logic [1:0] r3_in, r3_ctrl;
  logic [2:0] r3_ack;
  logic       r3_ready, r3_err;
  logic [5:0] r3_out;
  logic [2:0] r3_ovalid;

  int checks = 0;
  int errors = 0;

  bidim_demux #(.WIDTH(2), .DEPTH(4)) u_dut (
    .m_clk(clk), .m_rst(rst), .m_in(din), .m_ctrl(ctrl), .m_bcast(bcast),
    .m_valid(valid), .m_ready(ready), .m_out(dout), .m_out_valid(ovalid),
    .m_out_ack(ack), .m_err(err)
  );

  bidim_demux #(.WIDTH(2), .DEPTH(3)) u_dut3 (
    .m_clk(clk), .m_rst(r3_rst), .m_in(r3_in), .m_ctrl(r3_ctrl), .m_bcast(r3_bcast),
    .m_valid(r3_valid), .m_ready(r3_ready), .m_out(r3_out), .m_out_valid(r3_ovalid),
    .m_out_ack(r3_ack), .m_err(r3_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bcast = 1'b0; valid = 1'b0; din = '0; ctrl = 2'd3; ack = '0;
    r3_rst = 1'b1; r3_bcast = 1'b0; r3_valid = 1'b0; r3_in = '0; r3_ctrl = '0; r3_ack = '0;
    #1;
    chk("ready_in_reset", ready, 1'b1);
    tick;
    rst = 1'b0; r3_rst = 1'b0;
    #1;
    chk("rst_out", dout, 8'h00);
    chk("rst_ovalid", ovalid, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", ready, 1'b1);
    $display("reset done");

    // Single write to lane 2
    din = 2'b11; ctrl = 2'd2; valid = 1'b1;
    #1 chk("wr1_ready", ready, 1'b1);
    tick;
    valid = 1'b0; ctrl = 2'd0;
    #1;
    chk("wr1_out", dout, 8'b0011_0000);
    chk("wr1_ovalid", ovalid, 4'b0100);
    chk("wr1_ready_next", ready, 1'b1);
    $display("write lane2 data=3 out=%b", dout);

    // Backpressure on full lane 2, then release with ack in same cycle
    din = 2'b01; ctrl = 2'd2; valid = 1'b1;
    #1 chk("bp_ready", ready, 1'b0);
    tick;
    chk("bp_out_hold", dout, 8'b0011_0000);
    chk("bp_ovalid_hold", ovalid, 4'b0100);
    ack = 4'b0100;
    #1 chk("bp_ack_ready", ready, 1'b1);
    tick;
    valid = 1'b0; ack = 4'b0000;
    chk("bp_overwrite_out", dout, 8'b0001_0000);
    chk("bp_overwrite_ovalid", ovalid, 4'b0100);
    $display("overwrite lane2 data=1 out=%b", dout);

    // Ack alone empties lane 2 but keeps its data
    ack = 4'b0100;
    tick;
    ack = 4'b0000;
    chk("ack_empty_ovalid", ovalid, 4'b0000);
    chk("ack_empty_data", dout, 8'b0001_0000);

    // Fill lane 1, then broadcast stalled until lane 1 is acked
    din = 2'b01; ctrl = 2'd1; valid = 1'b1;
    tick;
    chk("fill1_out", dout, 8'b0001_0100);
    chk("fill1_ovalid", ovalid, 4'b0010);
    bcast = 1'b1; din = 2'b10; ctrl = 2'd3;
    #1 chk("bc_ready_blocked", ready, 1'b0);
    tick;
    chk("bc_ovalid_hold", ovalid, 4'b0010);
    chk("bc_out_hold", dout, 8'b0001_0100);
    ack = 4'b0010;
    #1 chk("bc_ready_acked", ready, 1'b1);
    tick;
    valid = 1'b0; bcast = 1'b0; ack = 4'b0000;
    chk("bc_out", dout, 8'b1010_1010);
    chk("bc_ovalid", ovalid, 4'b1111);
    $display("broadcast data=2 out=%b", dout);

    // Drain everything, then stream into lane 0 with ack every cycle
    ack = 4'b1111;
    tick;
    chk("drain_ovalid", ovalid, 4'b0000);
    ctrl = 2'd0; valid = 1'b1; ack = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      din = 2'(k % 4);
      #1 chk($sformatf("stream_ready_%0d", k), ready, 1'b1);
      tick;
      chk($sformatf("stream_out_%0d", k), dout, {6'b101010, 2'(k % 4)});
      chk($sformatf("stream_ovalid_%0d", k), ovalid, 4'b0001);
      $display("stream beat %0d out=%b ovalid=%b", k, dout, ovalid);
    end
    valid = 1'b0;
    tick;
    ack = 4'b0000;
    chk("stream_end_ovalid", ovalid, 4'b0000);

    // Out-of-range select on the 3-lane instance
    r3_in = 2'b10; r3_ctrl = 2'd1; r3_valid = 1'b1;
    tick;
    chk("r3_fill_out", r3_out, 6'b00_10_00);
    chk("r3_fill_ovalid", r3_ovalid, 3'b010);
    chk("r3_err_clear", r3_err, 1'b0);
    r3_in = 2'b11; r3_ctrl = 2'd3;
    #1 chk("r3_oor_ready", r3_ready, 1'b1);
    tick;
    r3_valid = 1'b0; r3_ctrl = 2'd0;
    chk("r3_oor_out", r3_out, 6'b00_10_00);
    chk("r3_oor_ovalid", r3_ovalid, 3'b010);
    chk("r3_oor_err", r3_err, 1'b1);
    tick; tick;
    chk("r3_err_sticky", r3_err, 1'b1);
    $display("out-of-range ctrl=3 err=%b", r3_err);
    r3_rst = 1'b1;
    tick;
    r3_rst = 1'b0;
    chk("r3_err_reset", r3_err, 1'b0);
    chk("r3_ovalid_reset", r3_ovalid, 3'b000);

    // Reset mid-operation with a simultaneous write and acks
    din = 2'b01; ctrl = 2'd0; valid = 1'b1;
    tick;
    din = 2'b11; ctrl = 2'd3;
    tick;
    chk("mid_ovalid", ovalid, 4'b1001);
    chk("mid_out", dout, 8'b1110_1001);
    din = 2'b11; ctrl = 2'd3; valid = 1'b1; ack = 4'b0001; rst = 1'b1;
    #1 chk("mid_rst_ready", ready, 1'b1);
    tick;
    rst = 1'b0; valid = 1'b0; ack = 4'b0000;
    chk("mid_rst_out", dout, 8'h00);
    chk("mid_rst_ovalid", ovalid, 4'b0000);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_ready_after", ready, 1'b1);
    $display("mid-stream reset out=%b ovalid=%b", dout, ovalid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
